// File: rtl/bn_requant_act.sv
// rtl/bn_requant_act.sv - rounding shift, ReLU/ReLU6 and OUT_W saturation of batch_norm rows into a small output FIFO.
// Optional BN_REQUANT_SAT_CNT_EN adds the sat_count port (lanes clipped by output saturation).
module bn_requant_act #(
  parameter int Data_Width = 32,
  parameter int N          = 4,
  parameter int OUT_W      = 8,
  parameter int DEPTH      = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N*Data_Width-1:0] in_row,
  input  logic                    In_Valid,
  input  logic [4:0]              shift,
  input  logic [1:0]              act_mode,
  input  logic [OUT_W-1:0]        relu6_max,
  output logic [N*OUT_W-1:0]      out_row,
  output logic                    Out_Valid,
  input  logic                    Out_Ready,
  output logic                    Overflow,
  output logic [15:0]             row_count
`ifdef BN_REQUANT_SAT_CNT_EN
  ,
  output logic [15:0]             sat_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic signed [Data_Width-1:0] SAT_MAX =
    {{(Data_Width-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [Data_Width-1:0] SAT_MIN = ~SAT_MAX;

  // One guard bit so x + 2^(sh-1) cannot wrap near the positive limit.
  function automatic logic signed [Data_Width-1:0] round_shift(
    input logic signed [Data_Width-1:0] x,
    input logic [4:0]                   sh
  );
    logic signed [Data_Width:0] sum;
    if (sh == 5'd0) return x;
    sum = {x[Data_Width-1], x} + ({{Data_Width{1'b0}}, 1'b1} << (sh - 5'd1));
    sum = sum >>> sh;
    return sum[Data_Width-1:0];
  endfunction

  function automatic logic signed [Data_Width-1:0] activate(
    input logic signed [Data_Width-1:0] y,
    input logic [1:0]                   mode,
    input logic signed [OUT_W-1:0]      rmax
  );
    logic signed [Data_Width-1:0] v;
    logic signed [Data_Width-1:0] lim;
    v   = y;
    lim = {{(Data_Width-OUT_W){rmax[OUT_W-1]}}, rmax};
    if ((mode == 2'd1 || mode == 2'd2) && y[Data_Width-1]) v = '0;
    if (mode == 2'd2 && v > lim) v = lim;
    return v;
  endfunction

  function automatic logic [OUT_W-1:0] saturate(input logic signed [Data_Width-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[OUT_W-1:0];
    if (v < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    return v[OUT_W-1:0];
  endfunction

  logic                    s1_valid_q;
  logic [N*Data_Width-1:0] s1_y_q, s1_y_d;
  logic [1:0]              s1_mode_q;
  logic [OUT_W-1:0]        s1_rmax_q;
  logic                    s2_valid_q;
  logic [N*OUT_W-1:0]      s2_data_q, s2_data_d;
  logic signed [Data_Width-1:0] act_v [N];

  logic [N*OUT_W-1:0]      mem [DEPTH];
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d, remain;
  logic [N*OUT_W-1:0]      out_row_q, out_row_d;
  logic                    overflow_q, overflow_d;
  logic [15:0]             row_count_q, row_count_d;
  logic                    full, empty, pop, push, wr_en;

  always_comb begin
    s1_y_d = '0;
    for (int i = 0; i < N; i++)
      s1_y_d[i*Data_Width +: Data_Width] = round_shift(in_row[i*Data_Width +: Data_Width], shift);
  end

  always_comb begin
    s2_data_d = '0;
    act_v     = '{default: '0};
    for (int i = 0; i < N; i++) begin
      act_v[i] = activate(s1_y_q[i*Data_Width +: Data_Width], s1_mode_q, s1_rmax_q);
      s2_data_d[i*OUT_W +: OUT_W] = saturate(act_v[i]);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_valid_q <= 1'b0;
      s1_y_q     <= '0;
      s1_mode_q  <= '0;
      s1_rmax_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= In_Valid;
      if (In_Valid) begin
        s1_y_q    <= s1_y_d;
        s1_mode_q <= act_mode;
        s1_rmax_q <= relu6_max;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) s2_data_q <= s2_data_d;
    end
  end

  // A push into a full FIFO is only accepted when a pop frees the head slot in the same cycle.
  always_comb begin
    full        = (count_q == CNT_W'(DEPTH));
    empty       = (count_q == '0);
    pop         = !empty && Out_Ready;
    push        = s2_valid_q;
    wr_en       = push && (!full || pop);
    overflow_d  = overflow_q || (push && full && !pop);
    rd_ptr_d    = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d    = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    remain      = pop   ? count_q - CNT_W'(1) : count_q;
    count_d     = wr_en ? remain + CNT_W'(1) : remain;
    row_count_d = pop   ? row_count_q + 16'd1 : row_count_q;
    out_row_d   = out_row_q;
    if (remain != '0)
      out_row_d = mem[rd_ptr_d];
    else if (wr_en)
      out_row_d = s2_data_q;
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr_q] <= s2_data_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_row_q   <= '0;
      overflow_q  <= 1'b0;
      row_count_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      out_row_q   <= out_row_d;
      overflow_q  <= overflow_d;
      row_count_q <= row_count_d;
    end
  end

  assign out_row   = out_row_q;
  assign Out_Valid = !empty;
  assign Overflow  = overflow_q;
  assign row_count = row_count_q;

`ifdef BN_REQUANT_SAT_CNT_EN
  localparam int NSAT_W = $clog2(N + 1);
  logic [NSAT_W-1:0] s2_nsat_q, s2_nsat_d;
  logic [15:0]       sat_count_q;
  logic [16:0]       sat_sum;

  always_comb begin
    s2_nsat_d = '0;
    for (int i = 0; i < N; i++)
      if (act_v[i] > SAT_MAX || act_v[i] < SAT_MIN) s2_nsat_d = s2_nsat_d + NSAT_W'(1);
    sat_sum = {1'b0, sat_count_q} + 17'(s2_nsat_q);
  end

  // Counted at the push point, so dropped rows still contribute.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s2_nsat_q   <= '0;
      sat_count_q <= '0;
    end else begin
      if (s1_valid_q) s2_nsat_q <= s2_nsat_d;
      if (s2_valid_q) sat_count_q <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end

  assign sat_count = sat_count_q;
`endif

endmodule

// File: tb/tb_bn_requant_act.sv
// tb/tb_bn_requant_act.sv - directed self-checking bench for bn_requant_act.
module tb_bn_requant_act;
  localparam int DW = 32, N = 4, OW = 8, DEPTH = 4;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N*DW-1:0] in_row;
  logic            In_Valid;
  logic [4:0]      shift;
  logic [1:0]      act_mode;
  logic [OW-1:0]   relu6_max;
  logic [N*OW-1:0] out_row;
  logic            Out_Valid;
  logic            Out_Ready;
  logic            Overflow;
  logic [15:0]     row_count;
`ifdef BN_REQUANT_SAT_CNT_EN
  logic [15:0]     sat_count;
`endif

  bn_requant_act #(.Data_Width(DW), .N(N), .OUT_W(OW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .in_row(in_row), .In_Valid(In_Valid), .shift(shift),
    .act_mode(act_mode), .relu6_max(relu6_max), .out_row(out_row), .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready), .Overflow(Overflow), .row_count(row_count)
`ifdef BN_REQUANT_SAT_CNT_EN
    , .sat_count(sat_count)
`endif
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int exp_rc = 0;
  logic [N*OW-1:0] got_q[$];
  logic [N*OW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] irow(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  function automatic logic [N*OW-1:0] orow(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // Record each transfer mid-cycle, before the edge that completes it.
  always @(negedge CLK)
    if (RST && Out_Valid && Out_Ready) got_q.push_back(out_row);

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [N*DW-1:0] r, input logic [4:0] sh, input logic [1:0] m,
                      input logic [OW-1:0] rm);
    in_row = r; shift = sh; act_mode = m; relu6_max = rm; In_Valid = 1'b1;
    tick();
    In_Valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    int k;
    n = exp_q.size();
    k = 0;
    while (got_q.size() < n && k < 60) begin
      tick();
      k++;
    end
    tick();
    check({tag, "_count"}, got_q.size(), n);
    while (got_q.size() > 0 && exp_q.size() > 0)
      check(tag, got_q.pop_front(), exp_q.pop_front());
    exp_rc += n;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic latency_check(input string tag, input logic [N*OW-1:0] exp);
    check({tag, "_lat1"}, Out_Valid, 0);
    tick();
    check({tag, "_lat2"}, Out_Valid, 0);
    tick();
    check({tag, "_lat3"}, Out_Valid, 1);
    check({tag, "_data"}, out_row, exp);
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b0; In_Valid = 1'b0; in_row = '0; shift = '0; act_mode = '0;
    relu6_max = '0; Out_Ready = 1'b0;
    repeat (2) tick();
    check("rst_valid", Out_Valid, 0);
    check("rst_row", out_row, 0);
    check("rst_ovf", Overflow, 0);
    check("rst_rc", row_count, 0);
    RST = 1'b1;
    tick();

    // First row and its 3-cycle latency.
    Out_Ready = 1'b1;
    send(irow(1, 2, 3, 4), 5'd0, 2'd0, 8'd0);
    latency_check("first", orow(1, 2, 3, 4));
    check("first_rc", row_count, 1);
    check("first_empty", Out_Valid, 0);
    got_q.delete();
    exp_rc = 1;

    send(irow(5, -5, 6, -6), 5'd1, 2'd0, 8'd0);
    exp_q.push_back(orow(3, -2, 3, -3));
    drain("round");

    send(irow(-10, 3, 50, 300), 5'd0, 2'd1, 8'd48);
    send(irow(-10, 3, 50, 300), 5'd0, 2'd2, 8'd48);
    send(irow(-10, 3, 50, 300), 5'd0, 2'd0, 8'd48);
    exp_q.push_back(orow(0, 3, 50, 127));
    exp_q.push_back(orow(0, 3, 48, 48));
    exp_q.push_back(orow(-10, 3, 50, 127));
    drain("act");
`ifdef BN_REQUANT_SAT_CNT_EN
    check("sat_count", sat_count, 2);
`endif

    // Guard-bit rounding, reserved mode, shift 31, negative relu6_max.
    send(irow(32'h7FFFFFFF, -200, -3, 254), 5'd1, 2'd3, 8'd0);
    send(irow(-1, 32'h80000000, 32'h7FFFFFFF, 32'h40000000), 5'd31, 2'd0, 8'd0);
    send(irow(-10, 3, 0, 100), 5'd0, 2'd2, 8'hFB);
    exp_q.push_back(orow(127, -100, -1, 127));
    exp_q.push_back(orow(0, -1, 1, 1));
    exp_q.push_back(orow(-5, -5, -5, -5));
    drain("edge");
    check("edge_rc", row_count, exp_rc);

    // Backpressure: fill, drop one, then drain in order.
    Out_Ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      send(irow(10 + i, 20 + i, 30 + i, 40 + i), 5'd0, 2'd0, 8'd0);
      exp_q.push_back(orow(10 + i, 20 + i, 30 + i, 40 + i));
    end
    repeat (3) tick();
    check("bp_valid", Out_Valid, 1);
    check("bp_ovf0", Overflow, 0);
    check("bp_head", out_row, orow(10, 20, 30, 40));
    send(irow(99, 99, 99, 99), 5'd0, 2'd0, 8'd0);
    repeat (3) tick();
    check("bp_ovf1", Overflow, 1);
    check("bp_hold", out_row, orow(10, 20, 30, 40));
    Out_Ready = 1'b1;
    drain("bp");
    check("bp_rc", row_count, exp_rc);
    check("bp_sticky", Overflow, 1);
    check("bp_empty", Out_Valid, 0);
    check("bp_last", out_row, orow(13, 23, 33, 43));

    // Async reset with two rows queued and one in stage 1.
    Out_Ready = 1'b0;
    send(irow(1, 1, 1, 1), 5'd0, 2'd0, 8'd0);
    send(irow(2, 2, 2, 2), 5'd0, 2'd0, 8'd0);
    repeat (2) tick();
    send(irow(3, 3, 3, 3), 5'd0, 2'd0, 8'd0);
    check("mid_pre", Out_Valid, 1);
    RST = 1'b0;
    #1;
    check("mid_valid", Out_Valid, 0);
    check("mid_row", out_row, 0);
    check("mid_ovf", Overflow, 0);
    check("mid_rc", row_count, 0);
    tick();
    RST = 1'b1;
    Out_Ready = 1'b1;
    got_q.delete();
    tick();
    send(irow(7, -8, 9, -10), 5'd0, 2'd0, 8'd0);
    latency_check("post", orow(7, -8, 9, -10));
    repeat (3) tick();
    check("post_count", got_q.size(), 1);
    check("post_rc", row_count, 1);
    got_q.delete();
    exp_rc = 1;

    // Full FIFO with push and pop in the same cycle.
    Out_Ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      send(irow(50 + i, 51 + i, 52 + i, 53 + i), 5'd0, 2'd0, 8'd0);
      exp_q.push_back(orow(50 + i, 51 + i, 52 + i, 53 + i));
    end
    repeat (3) tick();
    check("full_valid", Out_Valid, 1);
    for (int j = 0; j < 10; j++) begin
      if (j == 2) Out_Ready = 1'b1;
      send(irow(60 + j, 61 + j, 62 + j, 63 + j), 5'd0, 2'd0, 8'd0);
      exp_q.push_back(orow(60 + j, 61 + j, 62 + j, 63 + j));
    end
    drain("full");
    check("full_ovf", Overflow, 0);
    check("full_rc", row_count, exp_rc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bn_requant_act.md
Name: bn_requant_act

Overview:
- Downstream neighbour of batch_norm.
- Consumes its 32-bit per-lane signed output rows (out_row / OutBatch_Valid).
- Per lane: rounding arithmetic right shift, activation (none / ReLU / ReLU6), saturation to OUT_W-bit signed.
- Results are buffered in a small FIFO and presented on a valid/ready interface to the next layer's input buffer. batch_norm has no backpressure, so this block absorbs stalls and flags overflow.

Parameters:
- Data_Width, 32, input lane width (signed two's complement).
- N, 4, lanes per row.
- OUT_W, 8, output lane width (signed).
- DEPTH, 4, output FIFO depth in rows (power of 2, >=2).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  asynchronous active-low reset.
- in_row  in  N*Data_Width  row from batch_norm; lane i at [i*Data_Width +: Data_Width].
- In_Valid  in  1  in_row valid this cycle (driven by OutBatch_Valid).
- shift  in  5  right-shift amount 0..31, sampled with each accepted row.
- act_mode  in  2  0=none, 1=ReLU, 2=ReLU6, 3=reserved (behaves as 0); sampled with each row.
- relu6_max  in  OUT_W  quantized value of 6.0 for ReLU6 upper clamp; sampled with each row.
- out_row  out  N*OUT_W  result row; lane i at [i*OUT_W +: OUT_W].
- Out_Valid  out  1  FIFO non-empty.
- Out_Ready  in  1  consumer accepts; transfer when Out_Valid && Out_Ready.
- Overflow  out  1  sticky: a row was dropped because the FIFO was full.
- row_count  out  16  number of rows transferred out; wraps 0xFFFF->0.

Behaviour:
- Reset (RST=0, async): out_row=0, Out_Valid=0, Overflow=0, row_count=0, pipeline valids=0, FIFO empty (pointers=0). Any in-flight rows are discarded.
- Input is never stalled: every cycle with In_Valid=1 enters stage 1.
- Stage 1 (registered), per lane:
  - x = signed in_row lane.
  - If shift>0: y = (x + 2^(shift-1)) >>> shift, computed in Data_Width+1 bits so the add cannot wrap. Else y = x.
  - Stage 1 registers y, act_mode and relu6_max alongside the data.
- Stage 2 (registered), per lane:
  - mode 1 or 2: y<0 -> 0.
  - mode 2: y>relu6_max -> relu6_max. relu6_max is treated as signed; a negative value is a config error and the result is then relu6_max.
  - All modes: saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- FIFO push at end of stage 2 valid. Latency In_Valid -> Out_Valid is 3 cycles when the FIFO is empty and Out_Ready=1.
- FIFO output is registered from the read pointer (first-word presented, no bubble). out_row holds its value while Out_Valid && !Out_Ready.
- When empty, out_row holds the last popped value (0 after reset).
- Full:
  - Push with FIFO full and no pop in the same cycle: row dropped, Overflow set on the next edge and held until reset. FIFO contents are unchanged.
  - Push and pop in the same cycle when full: both occur, no drop, occupancy unchanged.
- Empty: pop is impossible (Out_Valid=0).
- Push into an empty FIFO with Out_Ready=1: the row appears on Out_Valid the next cycle, not combinationally.
- row_count increments once per transfer.
- Back-to-back In_Valid every cycle is supported; sustained throughput is 1 row/cycle when Out_Ready=1.

Optional Feature:
- Macro BN_REQUANT_SAT_CNT_EN.
- Defined: adds output port sat_count (16 bits, reset 0). It increments by the number of lanes in a row whose stage-2 value was clipped by the signed OUT_W saturation (not by ReLU/ReLU6 clamps), counted at FIFO push including dropped rows. It saturates at 0xFFFF.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then single row x=[1,2,3,4], shift=0, act_mode=0, Out_Ready=1 -> Out_Valid 3 cycles later, out_row lanes=[1,2,3,4], row_count=1.
- Rounding: x=[5,-5,6,-6], shift=1, mode 0 -> [3,-2,3,-3], i.e. (x+1)>>>1.
- Activation: x=[-10,3,50,300], shift=0, relu6_max=48. Mode 1 -> [0,3,50,127]. Mode 2 -> [0,3,48,48]. Mode 0 -> [-10,3,50,127]. With BN_REQUANT_SAT_CNT_EN, sat_count=+1 for modes 0 and 1 only.
- Backpressure: Out_Ready=0, push 4 rows (DEPTH) -> Out_Valid=1, Overflow=0. Push a 5th row -> dropped, Overflow=1. Then Out_Ready=1 -> the first 4 rows come out in order, unchanged; row_count=4.
- Full with simultaneous push/pop: FIFO full, Out_Ready=1 and In_Valid=1 every cycle for 10 cycles -> no drop, Overflow stays 0, output order preserved.
- Reset mid-operation: assert RST=0 with 2 rows in the FIFO and 1 in stage 1 -> Out_Valid=0, out_row=0, Overflow=0, row_count=0 immediately (async). After release, a new row is emitted correctly with latency 3.
